// File: rtl/bcd_pkg.sv
// Shared types and helpers for the sequential binary-to-BCD converter.
// Combinational only; no handshake of its own.
package bcd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } state_t;

  localparam int unsigned BCD_ADJ_THRESH = 5;

  // Decimal digit count of 2^width - 1 is floor(width*log10(2)) + 1.
  function automatic int bcd_digits_needed(input int width);
    return (width * 30103) / 100000 + 1;
  endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit pre-shift adjust: d >= 5 gets +3, wrapping within 4 bits.
// Purely combinational, zero latency, no backpressure.
module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [3:0] d_i,
  output logic [3:0] d_o
);

  assign d_o = (d_i >= 4'(BCD_ADJ_THRESH)) ? d_i + 4'd3 : d_i;

endmodule

// File: rtl/bcd_seq_conv.sv
// Multi-cycle binary-to-BCD converter, one bit per clock; out_valid rises WIDTH+1 edges after accept.
// Stalls in DONE while out_ready=0. Signed input handled under BCD_SEQ_CONV_SIGNED_EN.
module bcd_seq_conv
  import bcd_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_num,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_bcd,
  output logic                  out_neg,
  output logic                  out_ovf
);

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] bin_q, bin_d;
  logic [BW-1:0]    bcd_q, bcd_d, bcd_adj;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             last_q, last_d;
  logic             ovf_q, ovf_d;
  logic             neg_q, neg_d;
  logic [BW-1:0]    obcd_q, obcd_d;
  logic             oovf_q, oovf_d;
  logic             oneg_q, oneg_d;
  logic [WIDTH-1:0] load_mag;
  logic             load_neg;

`ifdef BCD_SEQ_CONV_SIGNED_EN
  // -2^(WIDTH-1) negates to itself, which read unsigned is the exact magnitude.
  assign load_neg = in_num[WIDTH-1];
  assign load_mag = load_neg ? -in_num : in_num;
`else
  assign load_neg = 1'b0;
  assign load_mag = in_num;
`endif

  for (genvar k = 0; k < DIGITS; k++) begin : g_adj
    bcd_digit_adj u_adj (
      .d_i (bcd_q[4*k +: 4]),
      .d_o (bcd_adj[4*k +: 4])
    );
  end

  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    ovf_d   = ovf_q;
    neg_d   = neg_q;
    obcd_d  = obcd_q;
    oovf_d  = oovf_q;
    oneg_d  = oneg_q;
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          bin_d   = load_mag;
          neg_d   = load_neg;
          bcd_d   = '0;
          cnt_d   = '0;
          last_d  = 1'b0;
          ovf_d   = 1'b0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // last_q marks that all WIDTH shifts are done; this edge only publishes.
        if (last_q) begin
          obcd_d  = bcd_q;
          oovf_d  = ovf_q;
          oneg_d  = neg_q;
          state_d = ST_DONE;
        end else begin
          {bcd_d, bin_d} = {bcd_adj[BW-2:0], bin_q, 1'b0};
          ovf_d          = ovf_q | bcd_adj[BW-1];
          if (cnt_q == CNT_LAST) begin
            last_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      ovf_q   <= 1'b0;
      neg_q   <= 1'b0;
      obcd_q  <= '0;
      oovf_q  <= 1'b0;
      oneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      ovf_q   <= ovf_d;
      neg_q   <= neg_d;
      obcd_q  <= obcd_d;
      oovf_q  <= oovf_d;
      oneg_q  <= oneg_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign out_bcd   = obcd_q;
  assign out_ovf   = oovf_q;
  assign out_neg   = oneg_q;

endmodule

// File: tb/tb_bcd_seq_conv.sv
// Directed bench for bcd_seq_conv: a 5-digit and a 4-digit instance, both WIDTH=16.
// Build with BCD_SEQ_CONV_SIGNED_EN defined to exercise signed-mode expectations.
module tb_bcd_seq_conv;
  import bcd_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid5 = 1'b0;
  logic        in_valid4 = 1'b0;
  logic [15:0] in_num = '0;
  logic        out_ready = 1'b1;

  logic        in_ready5, out_valid5, out_neg5, out_ovf5;
  logic [19:0] out_bcd5;
  logic        in_ready4, out_valid4, out_neg4, out_ovf4;
  logic [15:0] out_bcd4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  bcd_seq_conv #(.WIDTH(16), .DIGITS(5)) dut5 (
    .clk(clk), .rst(rst), .in_valid(in_valid5), .in_ready(in_ready5), .in_num(in_num),
    .out_valid(out_valid5), .out_ready(out_ready), .out_bcd(out_bcd5),
    .out_neg(out_neg5), .out_ovf(out_ovf5)
  );

  bcd_seq_conv #(.WIDTH(16), .DIGITS(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_num(in_num),
    .out_valid(out_valid4), .out_ready(out_ready), .out_bcd(out_bcd4),
    .out_neg(out_neg4), .out_ovf(out_ovf4)
  );

  task automatic start(input bit four, input logic [15:0] v);
    int guard = 0;
    while (!(four ? in_ready4 : in_ready5) && guard < 100) begin
      @(posedge clk); #1;
      guard++;
    end
    in_num = v;
    if (four) in_valid4 = 1'b1; else in_valid5 = 1'b1;
    @(posedge clk); #1;
    in_valid4 = 1'b0;
    in_valid5 = 1'b0;
  endtask

  task automatic wait_valid(input bit four, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!(four ? out_valid4 : out_valid5) && cyc < 100);
    if (!(four ? out_valid4 : out_valid5)) begin
      n_cmp++; n_err++;
      $display("FAIL timeout: out_valid not seen after %0d cycles, required within 100", cyc);
    end
  endtask

  task automatic test_reset;
    #1 rst = 1'b1;
    #3;
    n_cmp++; if (in_ready5 !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b want 1", in_ready5); end
    n_cmp++; if (out_valid5 !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid5); end
    n_cmp++; if (out_bcd5 !== 20'h0) begin n_err++; $display("FAIL rst_out_bcd: got %h want 00000", out_bcd5); end
    n_cmp++; if (out_neg5 !== 1'b0 || out_ovf5 !== 1'b0) begin n_err++; $display("FAIL rst_flags: got neg=%b ovf=%b want 0 0", out_neg5, out_ovf5); end
    n_cmp++; if (in_ready4 !== 1'b1 || out_valid4 !== 1'b0 || out_bcd4 !== 16'h0) begin
      n_err++; $display("FAIL rst_dut4: got rdy=%b vld=%b bcd=%h want 1 0 0000", in_ready4, out_valid4, out_bcd4);
    end
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_zero;
    int cyc;
    start(1'b0, 16'd0);
    wait_valid(1'b0, cyc);
    n_cmp++; if (cyc !== 17) begin n_err++; $display("FAIL zero_latency: got %0d edges want 17", cyc); end
    n_cmp++; if (out_bcd5 !== 20'h00000) begin n_err++; $display("FAIL zero_bcd: got %h want 00000", out_bcd5); end
    n_cmp++; if (out_ovf5 !== 1'b0 || out_neg5 !== 1'b0) begin n_err++; $display("FAIL zero_flags: got ovf=%b neg=%b want 0 0", out_ovf5, out_neg5); end
    @(posedge clk); #1;
    n_cmp++; if (in_ready5 !== 1'b1 || out_valid5 !== 1'b0) begin n_err++; $display("FAIL zero_return_idle: got rdy=%b vld=%b want 1 0", in_ready5, out_valid5); end
  endtask

  task automatic test_max;
    int cyc;
    logic [19:0] exp_bcd;
    logic        exp_neg;
`ifdef BCD_SEQ_CONV_SIGNED_EN
    exp_bcd = 20'h00001; exp_neg = 1'b1;
`else
    exp_bcd = 20'h65535; exp_neg = 1'b0;
`endif
    start(1'b0, 16'hFFFF);
    wait_valid(1'b0, cyc);
    n_cmp++; if (out_bcd5 !== exp_bcd) begin n_err++; $display("FAIL max_bcd: got %h want %h", out_bcd5, exp_bcd); end
    n_cmp++; if (out_neg5 !== exp_neg || out_ovf5 !== 1'b0) begin n_err++; $display("FAIL max_flags: got neg=%b ovf=%b want %b 0", out_neg5, out_ovf5, exp_neg); end
    @(posedge clk); #1;
  endtask

  task automatic test_msb_patterns;
    int cyc;
    logic [15:0] vin  [2];
    logic [19:0] vbcd [2];
    logic        vneg [2];
    vin[0] = 16'h8000; vbcd[0] = 20'h32768;
    vin[1] = 16'h7FFF; vbcd[1] = 20'h32767; vneg[1] = 1'b0;
`ifdef BCD_SEQ_CONV_SIGNED_EN
    vneg[0] = 1'b1;
`else
    vneg[0] = 1'b0;
`endif
    for (int i = 0; i < 2; i++) begin
      start(1'b0, vin[i]);
      wait_valid(1'b0, cyc);
      n_cmp++; if (out_bcd5 !== vbcd[i] || out_neg5 !== vneg[i]) begin
        n_err++; $display("FAIL msb_%0d: got bcd=%h neg=%b want %h %b", i, out_bcd5, out_neg5, vbcd[i], vneg[i]);
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_backpressure;
    int cyc;
    out_ready = 1'b0;
    start(1'b0, 16'd1234);
    wait_valid(1'b0, cyc);
    for (int i = 0; i < 10; i++) begin
      n_cmp++; if (out_bcd5 !== 20'h01234 || in_ready5 !== 1'b0 || out_valid5 !== 1'b1) begin
        n_err++; $display("FAIL stall_%0d: got bcd=%h rdy=%b vld=%b want 01234 0 1", i, out_bcd5, in_ready5, out_valid5);
      end
      in_valid5 = (i == 3);
      in_num    = (i == 3) ? 16'd999 : 16'd0;
      @(posedge clk); #1;
    end
    in_valid5 = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (out_valid5 !== 1'b0 || in_ready5 !== 1'b1) begin n_err++; $display("FAIL stall_release: got vld=%b rdy=%b want 0 1", out_valid5, in_ready5); end
    @(posedge clk); #1;
    n_cmp++; if (in_ready5 !== 1'b1 || out_bcd5 !== 20'h01234) begin
      n_err++; $display("FAIL stall_ignored_pulse: got rdy=%b bcd=%h want 1 01234", in_ready5, out_bcd5);
    end
  endtask

  task automatic test_overflow;
    int cyc;
    start(1'b1, 16'd12345);
    wait_valid(1'b1, cyc);
    n_cmp++; if (out_bcd4 !== 16'h2345 || out_ovf4 !== 1'b1) begin n_err++; $display("FAIL ovf_12345: got bcd=%h ovf=%b want 2345 1", out_bcd4, out_ovf4); end
    @(posedge clk); #1;
    start(1'b1, 16'd9999);
    wait_valid(1'b1, cyc);
    n_cmp++; if (out_bcd4 !== 16'h9999 || out_ovf4 !== 1'b0) begin n_err++; $display("FAIL ovf_9999: got bcd=%h ovf=%b want 9999 0", out_bcd4, out_ovf4); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_midop;
    int cyc;
    start(1'b0, 16'd40000);
    repeat (4) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    n_cmp++; if (out_valid5 !== 1'b0 || in_ready5 !== 1'b1) begin n_err++; $display("FAIL midop_abort: got vld=%b rdy=%b want 0 1", out_valid5, in_ready5); end
    n_cmp++; if (out_bcd5 !== 20'h0) begin n_err++; $display("FAIL midop_bcd_cleared: got %h want 00000", out_bcd5); end
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (out_valid5 !== 1'b0) begin n_err++; $display("FAIL midop_no_partial: got vld=%b want 0", out_valid5); end
    start(1'b0, 16'd7);
    wait_valid(1'b0, cyc);
    n_cmp++; if (out_bcd5 !== 20'h00007) begin n_err++; $display("FAIL midop_next: got %h want 00007", out_bcd5); end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back;
    int cyc;
    out_ready = 1'b1;
    in_num    = 16'd4321;
    in_valid5 = 1'b1;
    @(posedge clk); #1;
    in_num = 16'd100;
    wait_valid(1'b0, cyc);
    n_cmp++; if (out_bcd5 !== 20'h04321) begin n_err++; $display("FAIL b2b_first: got %h want 04321", out_bcd5); end
    @(posedge clk); #1;
    n_cmp++; if (in_ready5 !== 1'b1) begin n_err++; $display("FAIL b2b_idle: got rdy=%b want 1", in_ready5); end
    @(posedge clk); #1;
    n_cmp++; if (in_ready5 !== 1'b0) begin n_err++; $display("FAIL b2b_accept: got rdy=%b want 0", in_ready5); end
    in_valid5 = 1'b0;
    wait_valid(1'b0, cyc);
    n_cmp++; if (cyc !== 17) begin n_err++; $display("FAIL b2b_latency: got %0d edges want 17", cyc); end
    n_cmp++; if (out_bcd5 !== 20'h00100) begin n_err++; $display("FAIL b2b_second: got %h want 00100", out_bcd5); end
    @(posedge clk); #1;
  endtask

  initial begin
    assert (bcd_digits_needed(16) == 5 && bcd_digits_needed(13) == 4);
    test_reset();
    test_zero();
    test_max();
    test_msb_patterns();
    test_backpressure();
    test_overflow();
    test_reset_midop();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
